// File: rtl/conv_window_streamer.sv
// Image memory with NUM_UNITS window read units streaming a k x k window in row-major order.
// Optional macro CONV_WINDOW_ZERO_PAD_EN: out-of-image elements read as zero instead of wrapping.
module conv_window_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int NUM_UNITS    = 2,
    parameter int MAX_KERNEL   = 7,
    localparam int ADDR_WIDTH  = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
    localparam int KW          = $clog2(MAX_KERNEL+1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [ADDR_WIDTH-1:0]                  wr_addr,
    input  logic [DATA_WIDTH-1:0]                  wr_data,
    input  logic                                   start,
    input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0]   start_addr,
    input  logic [KW-1:0]                          kernel_dim,
    input  logic                                   en,
    input  logic                                   step,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   out_data,
    output logic                                   out_valid,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done
);
    localparam int NPIX = IMAGE_WIDTH*IMAGE_HEIGHT;
    localparam int AW1  = ADDR_WIDTH+1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                 state_q, state_d;
    logic [KW-1:0]                          k_q, k_d, row_q, row_d, col_q, col_d;
    logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0]   base_q, base_d;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]   out_data_q, out_data_d, rd_data;
    logic                                   out_valid_q, out_valid_d;
    logic                                   out_last_q, out_last_d;
    logic                                   done_q, done_d;
    logic                                   issue, col_end, row_end;
    logic [DATA_WIDTH-1:0]                  mem [NPIX];

    // Memory is never reset; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign issue   = (state_q == RUN) && en && step;
    assign col_end = (col_q == k_q - KW'(1));
    assign row_end = (row_q == k_q - KW'(1));

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        logic [AW1-1:0]        lin;
        logic [ADDR_WIDTH-1:0] addr;
        assign lin  = AW1'(base_q[u]) + AW1'(row_q) * AW1'(IMAGE_WIDTH) + AW1'(col_q);
        assign addr = ADDR_WIDTH'(lin % AW1'(NPIX));
`ifdef CONV_WINDOW_ZERO_PAD_EN
        logic [AW1-1:0] sc, sr;
        logic           pad;
        assign sc  = AW1'(base_q[u]) % AW1'(IMAGE_WIDTH);
        assign sr  = AW1'(base_q[u]) / AW1'(IMAGE_WIDTH);
        assign pad = (sc + AW1'(col_q) >= AW1'(IMAGE_WIDTH)) ||
                     (sr + AW1'(row_q) >= AW1'(IMAGE_HEIGHT));
        assign rd_data[u] = pad ? '0 : mem[addr];
`else
        assign rd_data[u] = mem[addr];
`endif
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        base_d      = base_q;
        out_valid_d = issue;
        out_last_d  = issue && col_end && row_end;
        out_data_d  = issue ? rd_data : out_data_q;
        done_d      = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start && (kernel_dim != '0) && (kernel_dim <= KW'(MAX_KERNEL))) begin
                    state_d = RUN;
                    k_d     = kernel_dim;
                    base_d  = start_addr;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (!col_end) begin
                        col_d = col_q + KW'(1);
                    end else if (!row_end) begin
                        col_d = '0;
                        row_d = row_q + KW'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            base_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_q      <= base_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer: window passes, stepping/enable gaps, edges, reset abort, write collision.
module tb_conv_window_streamer;
    typedef int vec_t [9];

    logic            clk = 1'b0;
    logic            reset, wr_en, start, en, step;
    logic [5:0]      wr_addr;
    logic [15:0]     wr_data;
    logic [1:0][5:0] start_addr;
    logic [2:0]      kernel_dim;
    logic [1:0][15:0] out_data;
    logic            out_valid, out_last, busy, done;
    int              total = 0;
    int              bad = 0;

    conv_window_streamer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_addr(start_addr), .kernel_dim(kernel_dim), .en(en), .step(step),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a pass and walks it, checking every cycle's valid plus each beat's data/last.
    // alt: step only on even cycles; fz: first of 3 cycles with en=0 (negative disables).
    task automatic run_pass(input string tag, input logic [5:0] a0, input logic [5:0] a1,
                            input logic [2:0] k, input vec_t e0, input vec_t e1,
                            input int n, input bit alt, input int fz);
        int  idx;
        bit  s, fin;
        idx = 0;
        fin = 0;
        @(negedge clk);
        start = 1; start_addr[0] = a0; start_addr[1] = a1; kernel_dim = k; en = 1; step = 0;
        @(negedge clk);
        start = 0;
        chk({tag, ".busy_start"}, busy, 1);
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            en = !(cyc >= fz && cyc < fz + 3);
            s  = (alt ? (cyc % 2 == 0) : 1'b1) && (idx < n);
            step = s;
            @(negedge clk);
            chk({tag, ".valid"}, out_valid, s && en);
            if (s && en) begin
                chk($sformatf("%s.u0[%0d]", tag, idx), out_data[0], e0[idx]);
                chk($sformatf("%s.u1[%0d]", tag, idx), out_data[1], e1[idx]);
                chk($sformatf("%s.last[%0d]", tag, idx), out_last, idx == n - 1);
                idx++;
                if (idx == n) begin
                    step = 0; en = 1;
                    chk({tag, ".busy_last"}, busy, 1);
                    chk({tag, ".done_early"}, done, 0);
                    @(negedge clk);
                    chk({tag, ".done"}, done, 1);
                    chk({tag, ".busy_end"}, busy, 0);
                    chk({tag, ".valid_end"}, out_valid, 0);
                    @(negedge clk);
                    chk({tag, ".done_pulse"}, done, 0);
                    fin = 1;
                end
            end
        end
        if (!fin) begin
            total++; bad++;
            $error("FAIL %s.timeout observed=%0d beats expected=%0d", tag, idx, n);
        end
        step = 0; en = 1;
    endtask

    initial begin
        vec_t e0, e1;
        reset = 1; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0;
        start_addr = '0; kernel_dim = 0; en = 1; step = 0;

        // Load image while reset is held: writes must still land.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            wr_en = 1; wr_addr = 6'(i); wr_data = 16'(3 * i);
        end
        @(negedge clk);
        wr_en = 0;
        chk("rst.valid", out_valid, 0);
        chk("rst.last", out_last, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.data", out_data, 0);
        reset = 0;

        e0 = '{0, 3, 6, 24, 27, 30, 48, 51, 54};
        e1 = '{12, 15, 18, 36, 39, 42, 60, 63, 66};
        run_pass("basic", 6'd0, 6'd4, 3'd3, e0, e1, 9, 1'b0, -10);
        run_pass("alt", 6'd0, 6'd4, 3'd3, e0, e1, 9, 1'b1, -10);
        run_pass("freeze", 6'd0, 6'd4, 3'd3, e0, e1, 9, 1'b0, 4);

`ifdef CONV_WINDOW_ZERO_PAD_EN
        e0 = '{18, 21, 0, 42, 45, 0, 66, 69, 0};
        e1 = '{168, 171, 174, 0, 0, 0, 0, 0, 0};
`else
        e0 = '{18, 21, 24, 42, 45, 48, 66, 69, 72};
        e1 = '{168, 171, 174, 0, 3, 6, 24, 27, 30};
`endif
        run_pass("edge", 6'd6, 6'd56, 3'd3, e0, e1, 9, 1'b0, -10);

        // Illegal kernel size: start ignored.
        @(negedge clk);
        start = 1; kernel_dim = 0; step = 1;
        @(negedge clk);
        start = 0;
        chk("k0.busy", busy, 0);
        @(negedge clk);
        chk("k0.valid", out_valid, 0);
        step = 0;

        e0 = '{15, 0, 0, 0, 0, 0, 0, 0, 0};
        e1 = '{189, 0, 0, 0, 0, 0, 0, 0, 0};
        run_pass("k1", 6'd5, 6'd63, 3'd1, e0, e1, 1, 1'b0, -10);

        // Abort a pass with reset after the 4th beat.
        e0 = '{0, 3, 6, 24, 27, 30, 48, 51, 54};
        e1 = '{12, 15, 18, 36, 39, 42, 60, 63, 66};
        @(negedge clk);
        start = 1; start_addr[0] = 0; start_addr[1] = 4; kernel_dim = 3;
        @(negedge clk);
        start = 0; step = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort.u0[%0d]", i), out_data[0], e0[i]);
        end
        reset = 1; step = 0;
        @(negedge clk);
        chk("abort.busy", busy, 0);
        chk("abort.valid", out_valid, 0);
        chk("abort.done", done, 0);
        reset = 0;
        @(negedge clk);
        chk("abort.done_after", done, 0);
        run_pass("after_abort", 6'd0, 6'd4, 3'd3, e0, e1, 9, 1'b0, -10);

        // Write to addr 9 in the same cycle its read issues: old data returned.
        @(negedge clk);
        start = 1; start_addr[0] = 9; start_addr[1] = 9; kernel_dim = 1;
        @(negedge clk);
        start = 0; step = 1; wr_en = 1; wr_addr = 9; wr_data = 500;
        @(negedge clk);
        step = 0; wr_en = 0;
        chk("rdw.valid", out_valid, 1);
        chk("rdw.u0", out_data[0], 27);
        chk("rdw.last", out_last, 1);
        @(negedge clk);
        chk("rdw.done", done, 1);
        e0 = '{500, 0, 0, 0, 0, 0, 0, 0, 0};
        e1 = '{500, 0, 0, 0, 0, 0, 0, 0, 0};
        run_pass("rdw_new", 6'd9, 6'd9, 3'd1, e0, e1, 1, 1'b0, -10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
